// File: rtl/ias_pkg.sv
// Shared IAS definitions: control-unit phase encoding, opcode constants and opcode classes.
// Imported by the sequencer, its opcode decoder and the sequencer interface.
package ias_pkg;

  localparam int unsigned IasAddrW = 12;
  localparam int unsigned IasWordW = 40;
  localparam int unsigned IasOpcW  = 8;
  localparam int unsigned IasHalfW = IasWordW / 2;

  typedef enum logic [1:0] {
    PhFetch   = 2'b00,
    PhDecode  = 2'b01,
    PhExecute = 2'b10
  } phase_e;

  typedef enum logic [2:0] {
    OpNop     = 3'd0,
    OpLoad    = 3'd1,
    OpArith   = 3'd2,
    OpJump    = 3'd3,
    OpCjump   = 3'd4,
    OpStore   = 3'd5,
    OpShift   = 3'd6,
    OpIllegal = 3'd7
  } op_class_e;

  localparam logic [IasOpcW-1:0] OpcNop         = 8'h00;
  localparam logic [IasOpcW-1:0] OpcLoadMx      = 8'h01;
  localparam logic [IasOpcW-1:0] OpcLoadNegMx   = 8'h02;
  localparam logic [IasOpcW-1:0] OpcLoadAbsMx   = 8'h03;
  localparam logic [IasOpcW-1:0] OpcLoadNAbsMx  = 8'h04;
  localparam logic [IasOpcW-1:0] OpcAddMx       = 8'h05;
  localparam logic [IasOpcW-1:0] OpcSubMx       = 8'h06;
  localparam logic [IasOpcW-1:0] OpcAddAbsMx    = 8'h07;
  localparam logic [IasOpcW-1:0] OpcSubAbsMx    = 8'h08;
  localparam logic [IasOpcW-1:0] OpcLoadMqMx    = 8'h09;
  localparam logic [IasOpcW-1:0] OpcLoadMq      = 8'h0A;
  localparam logic [IasOpcW-1:0] OpcMul         = 8'h0B;
  localparam logic [IasOpcW-1:0] OpcDiv         = 8'h0C;
  localparam logic [IasOpcW-1:0] OpcJumpL       = 8'h0D;
  localparam logic [IasOpcW-1:0] OpcJumpR       = 8'h0E;
  localparam logic [IasOpcW-1:0] OpcJumpPlusL   = 8'h0F;
  localparam logic [IasOpcW-1:0] OpcJumpPlusR   = 8'h10;
  localparam logic [IasOpcW-1:0] OpcStor        = 8'h21;
  localparam logic [IasOpcW-1:0] OpcStorL       = 8'h12;
  localparam logic [IasOpcW-1:0] OpcStorR       = 8'h13;
  localparam logic [IasOpcW-1:0] OpcLsh         = 8'h14;
  localparam logic [IasOpcW-1:0] OpcRsh         = 8'h15;

endpackage

// File: rtl/ias_phase_sequencer_if.sv
// Bundle between the phase sequencer and its neighbours (control unit, instruction memory,
// datapath). The master side drives phase, memory data and AC status.
interface ias_phase_sequencer_if #(
  parameter int unsigned ADDR_W = ias_pkg::IasAddrW,
  parameter int unsigned WORD_W = ias_pkg::IasWordW,
  parameter int unsigned OPC_W  = ias_pkg::IasOpcW
);
  import ias_pkg::*;

  logic [1:0]        state;
  logic [WORD_W-1:0] mem_rdata;
  logic              ac_nonneg;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] pc;
  logic [OPC_W-1:0]  ir;
  logic [ADDR_W-1:0] mar;
  logic              ibr_valid;
  op_class_e         op_class;
  logic              exec_strobe;
  logic              jump_taken;
  logic              illegal_op;
  logic              seq_error;

  modport master (
    output state, mem_rdata, ac_nonneg,
    input  mem_rd, mem_addr, pc, ir, mar, ibr_valid, op_class,
    input  exec_strobe, jump_taken, illegal_op, seq_error
  );

  modport slave (
    input  state, mem_rdata, ac_nonneg,
    output mem_rd, mem_addr, pc, ir, mar, ibr_valid, op_class,
    output exec_strobe, jump_taken, illegal_op, seq_error
  );

endinterface

// File: rtl/ias_opcode_decoder.sv
// Combinational IAS opcode classifier; also flags jumps, conditional jumps and right-half targets.
module ias_opcode_decoder
  import ias_pkg::*;
(
  input  logic [IasOpcW-1:0] opcode_i,
  output op_class_e          op_class_o,
  output logic               is_jump_o,
  output logic               is_cond_o,
  output logic               jump_right_o
);

  always_comb begin
    op_class_o   = OpIllegal;
    is_jump_o    = 1'b0;
    is_cond_o    = 1'b0;
    jump_right_o = 1'b0;
    case (opcode_i)
      OpcNop: op_class_o = OpNop;
      OpcLoadMx, OpcLoadNegMx, OpcLoadAbsMx, OpcLoadNAbsMx, OpcLoadMqMx, OpcLoadMq:
        op_class_o = OpLoad;
      OpcAddMx, OpcSubMx, OpcAddAbsMx, OpcSubAbsMx, OpcMul, OpcDiv:
        op_class_o = OpArith;
      OpcJumpL: begin
        op_class_o = OpJump;
        is_jump_o  = 1'b1;
      end
      OpcJumpR: begin
        op_class_o   = OpJump;
        is_jump_o    = 1'b1;
        jump_right_o = 1'b1;
      end
      OpcJumpPlusL: begin
        op_class_o = OpCjump;
        is_jump_o  = 1'b1;
        is_cond_o  = 1'b1;
      end
      OpcJumpPlusR: begin
        op_class_o   = OpCjump;
        is_jump_o    = 1'b1;
        is_cond_o    = 1'b1;
        jump_right_o = 1'b1;
      end
      OpcStor, OpcStorL, OpcStorR: op_class_o = OpStore;
      OpcLsh, OpcRsh:              op_class_o = OpShift;
      default: ;
    endcase
  end

endmodule

// File: rtl/ias_phase_sequencer.sv
// Follows the control unit's FETCH/DECODE/EXECUTE phases: issues word reads, splits words via
// the IBR into ir/mar, and updates PC on execute. Pulses and mem_rd are combinational.
module ias_phase_sequencer
  import ias_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IasAddrW,
  parameter int unsigned       WORD_W   = IasWordW,
  parameter int unsigned       OPC_W    = IasOpcW,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input logic                  clk,
  input logic                  reset,
  ias_phase_sequencer_if.slave bus_io
);

  localparam int unsigned HalfW = WORD_W / 2;

  logic [1:0]        prev_state_q, prev_state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [OPC_W-1:0]  ir_q, ir_d;
  logic [HalfW-1:0]  ibr_q, ibr_d;
  logic              ibr_valid_q, ibr_valid_d;
  logic              right_pending_q, right_pending_d;
  logic              seq_error_q, seq_error_d;

  logic      legal, act, take_jump;
  logic      mem_rd, exec_strobe, illegal_op;
  op_class_e op_class;
  logic      is_jump, is_cond, jump_right;

  ias_opcode_decoder u_decoder (
    .opcode_i    (ir_q),
    .op_class_o  (op_class),
    .is_jump_o   (is_jump),
    .is_cond_o   (is_cond),
    .jump_right_o(jump_right)
  );

  always_comb begin
    legal = (prev_state_q == PhExecute && bus_io.state == PhFetch)  ||
            (prev_state_q == PhFetch   && bus_io.state == PhDecode) ||
            (prev_state_q == PhDecode  && bus_io.state == PhExecute);
    // Once a phase-order violation is seen the block stays frozen until reset.
    act = legal && !seq_error_q;

    prev_state_d    = bus_io.state;
    seq_error_d     = seq_error_q | ~legal;
    pc_d            = pc_q;
    mar_d           = mar_q;
    ir_d            = ir_q;
    ibr_d           = ibr_q;
    ibr_valid_d     = ibr_valid_q;
    right_pending_d = right_pending_q;
    mem_rd          = 1'b0;
    exec_strobe     = 1'b0;
    illegal_op      = 1'b0;
    take_jump       = 1'b0;

    if (act) begin
      case (bus_io.state)
        PhFetch: mem_rd = ~ibr_valid_q;
        PhDecode: begin
          if (ibr_valid_q) begin
            ir_d        = ibr_q[HalfW-1 -: OPC_W];
            mar_d       = ibr_q[ADDR_W-1:0];
            ibr_valid_d = 1'b0;
            pc_d        = pc_q + ADDR_W'(1);
          end else if (right_pending_q) begin
            ir_d            = bus_io.mem_rdata[HalfW-1 -: OPC_W];
            mar_d           = bus_io.mem_rdata[ADDR_W-1:0];
            right_pending_d = 1'b0;
            pc_d            = pc_q + ADDR_W'(1);
          end else begin
            ir_d        = bus_io.mem_rdata[WORD_W-1 -: OPC_W];
            mar_d       = bus_io.mem_rdata[WORD_W-OPC_W-1 -: ADDR_W];
            ibr_d       = bus_io.mem_rdata[HalfW-1:0];
            ibr_valid_d = 1'b1;
          end
        end
        PhExecute: begin
          exec_strobe = 1'b1;
          illegal_op  = (op_class == OpIllegal);
          take_jump   = is_jump && (!is_cond || bus_io.ac_nonneg);
          // A taken jump discards any right instruction still held in the IBR.
          if (take_jump) begin
            pc_d            = mar_q;
            ibr_valid_d     = 1'b0;
            right_pending_d = jump_right;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_state_q    <= PhExecute;
      pc_q            <= PC_RESET;
      mar_q           <= '0;
      ir_q            <= '0;
      ibr_q           <= '0;
      ibr_valid_q     <= 1'b0;
      right_pending_q <= 1'b0;
      seq_error_q     <= 1'b0;
    end else begin
      prev_state_q    <= prev_state_d;
      pc_q            <= pc_d;
      mar_q           <= mar_d;
      ir_q            <= ir_d;
      ibr_q           <= ibr_d;
      ibr_valid_q     <= ibr_valid_d;
      right_pending_q <= right_pending_d;
      seq_error_q     <= seq_error_d;
    end
  end

  assign bus_io.mem_rd      = mem_rd;
  assign bus_io.mem_addr    = pc_q;
  assign bus_io.pc          = pc_q;
  assign bus_io.ir          = ir_q;
  assign bus_io.mar         = mar_q;
  assign bus_io.ibr_valid   = ibr_valid_q;
  assign bus_io.op_class    = op_class;
  assign bus_io.exec_strobe = exec_strobe;
  assign bus_io.jump_taken  = take_jump;
  assign bus_io.illegal_op  = illegal_op;
  assign bus_io.seq_error   = seq_error_q;

endmodule
